// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter: round-robin share of one combinational ALU between two requesters.
// Latches the winning op, drives the ALU for one EXEC cycle, returns a tagged response.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [2:0]  r0_ctrl,
   input  logic [31:0] r0_a,
   input  logic [31:0] r0_b,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [2:0]  r1_ctrl,
   input  logic [31:0] r1_a,
   input  logic [31:0] r1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_err,
   output logic [2:0]  alu_ctrl,
   output logic [31:0] alu_srcA,
   output logic [31:0] alu_srcB,
   input  logic [31:0] alu_result,
   input  logic        alu_zero
);
   localparam logic [2:0] OP_ILLEGAL = 3'b111;
   localparam logic [2:0] OP_ADD     = 3'b010;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   typedef struct packed {
      logic [2:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   state_t      r_state, w_next;
   op_t         r_op, w_sel;
   logic        r_last_grant, r_id, r_zero, r_err;
   logic [31:0] r_result;
   logic        w_any, w_gnt, w_accept, w_illegal;

   assign w_any     = r0_valid | r1_valid;
   // On contention the requester not served last wins.
   assign w_gnt     = (r0_valid & r1_valid) ? ~r_last_grant : r1_valid;
   assign w_accept  = (r_state == IDLE) & w_any & ~rst;
   assign r0_ready  = w_accept & ~w_gnt;
   assign r1_ready  = w_accept & w_gnt;
   assign w_sel     = w_gnt ? {r1_ctrl, r1_a, r1_b} : {r0_ctrl, r0_a, r0_b};
   assign w_illegal = (w_sel.ctrl == OP_ILLEGAL);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_illegal ? RESP : EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_op         <= {OP_ADD, 32'd0, 32'd0};
         r_id         <= 1'b0;
         r_result     <= '0;
         r_zero       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_last_grant <= w_gnt;
            r_id         <= w_gnt;
            // Illegal ops never reach the ALU operand registers.
            if (w_illegal) begin
               r_result <= '0;
               r_zero   <= 1'b0;
               r_err    <= 1'b1;
            end else begin
               r_op <= w_sel;
            end
         end
         if (r_state == EXEC) begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
            r_err    <= 1'b0;
         end
      end
   end

   assign rsp_valid  = (r_state == RESP);
   assign rsp_id     = r_id;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_err    = r_err;
   assign alu_ctrl   = r_op.ctrl;
   assign alu_srcA   = r_op.a;
   assign alu_srcB   = r_op.b;
endmodule
